// File: rtl/axil_regbank_pkg.sv
// Shared types and helpers for the parametrised AXI4-Lite register bank.
// Response codes, FSM state enums and the byte-lane merge used on every write.
package axil_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Widest supported data path; narrower users zero-extend and truncate.
   localparam int MAX_DW = 64;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   function automatic logic [MAX_DW-1:0] strb_merge(
      input logic [MAX_DW-1:0]   old_val,
      input logic [MAX_DW-1:0]   new_val,
      input logic [MAX_DW/8-1:0] strb
   );
      logic [MAX_DW-1:0] merged;
      merged = old_val;
      for (int b = 0; b < MAX_DW / 8; b++) begin
         if (strb[b]) begin
            merged[b*8 +: 8] = new_val[b*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers with byte strobes,
// optional read-only status slots, SLVERR on unmapped or read-only writes.
module axil_regbank
   import axil_regbank_pkg::*;
#(
   parameter int                  C_S_AXI_DATA_WIDTH = 32,
   parameter int                  NUM_REGS           = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
   localparam int                 C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH / 8)
) (
   input  logic                                   ACLK,
   input  logic                                   ARESETN,

   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,

   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,

   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,

   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,

   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,

   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]                    reg_wr_pulse,
   input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_status
);

   localparam int DW    = C_S_AXI_DATA_WIDTH;
   localparam int SW    = DW / 8;
   localparam int LSB   = $clog2(SW);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int PAD_N = 2 ** IDX_W;

   // Index decode padded to the full index space so unmapped slots decode cleanly.
   localparam logic [PAD_N-1:0] VALID_PAD = PAD_N'({NUM_REGS{1'b1}});
   localparam logic [PAD_N-1:0] RO_PAD    = PAD_N'(RO_MASK);

   logic [NUM_REGS-1:0][DW-1:0] reg_arr;
   logic [NUM_REGS-1:0][DW-1:0] hw_arr;

   assign hw_arr  = hw_status;
   assign reg_out = reg_arr;

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   wr_state_t            wr_state_q, wr_state_d;
   logic                 awready_q, awready_d;
   logic                 wready_q, wready_d;
   logic                 aw_held_q, aw_held_d;
   logic                 w_held_q, w_held_d;
   logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic [SW-1:0]        wstrb_q, wstrb_d;
   logic [1:0]           bresp_q, bresp_d;
   logic [NUM_REGS-1:0]  pulse_q, pulse_d;
   logic                 reg_we;

   logic aw_hs, w_hs;
   assign aw_hs = S_AXI_AWVALID && awready_q;
   assign w_hs  = S_AXI_WVALID && wready_q;

   // NOTE: every signal this block drives is given a default first, so no
   // path through the case can leave one unassigned and infer a latch.
   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_idx_d   = aw_idx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      pulse_d    = '0;
      reg_we     = 1'b0;

      unique case (wr_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = S_AXI_WDATA;
               wstrb_d  = S_AXI_WSTRB;
            end
            // Commit on the cycle the second half of the pair arrives.
            if (aw_held_d && w_held_d) begin
               wr_state_d = W_RESP;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               if (VALID_PAD[aw_idx_d] && !RO_PAD[aw_idx_d]) begin
                  reg_we            = 1'b1;
                  bresp_d           = RESP_OKAY;
                  pulse_d[aw_idx_d] = 1'b1;
               end else begin
                  bresp_d = RESP_SLVERR;
               end
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               wr_state_d = W_IDLE;
            end
         end
      endcase

      awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
      wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
   end

   // NOTE: state flops use non-blocking assignments only, so every reader of a
   // _q signal sees the pre-edge value regardless of process ordering.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_q <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= RESP_OKAY;
         pulse_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_idx_q   <= aw_idx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         pulse_q    <= pulse_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = (wr_state_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign reg_wr_pulse  = pulse_q;

   // ------------------------------------------------------------------
   // Register array
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
         assign reg_arr[i] = '0;
      end else begin : g_rw
         logic [DW-1:0] val_q, val_d;

         always_comb begin
            val_d = val_q;
            if (reg_we && (aw_idx_d == IDX_W'(i))) begin
               val_d = DW'(strb_merge(MAX_DW'(val_q), MAX_DW'(wdata_d), (MAX_DW/8)'(wstrb_d)));
            end
         end

         // NOTE: this is a small flop array rather than a RAM, so every entry
         // is reset and a reset always leaves the bank reading zero.
         always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
               val_q <= '0;
            end else begin
               val_q <= val_d;
            end
         end

         assign reg_arr[i] = val_q;
      end
   end

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   rd_state_t         rd_state_q, rd_state_d;
   logic              arready_q, arready_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [IDX_W-1:0]  ar_idx;

   assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];

   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;

      unique case (rd_state_q)
         R_IDLE: begin
            if (S_AXI_ARVALID && arready_q) begin
               rd_state_d = R_DATA;
               // reg_arr holds the pre-edge value, so a same-cycle write is not seen.
               if (!VALID_PAD[ar_idx]) begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end else if (RO_PAD[ar_idx]) begin
                  rdata_d = hw_arr[ar_idx];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = reg_arr[ar_idx];
                  rresp_d = RESP_OKAY;
               end
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               rd_state_d = R_IDLE;
            end
         end
      endcase

      arready_d = (rd_state_d == R_IDLE);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = (rd_state_q == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

   // Protection bits and byte-offset address bits carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

endmodule

// File: tb/tb_axil_regbank.sv
// Bench for axil_regbank: a transaction-level model of the register map checked
// every cycle, plus directed AXI4-Lite transfers with literal expectations.
module tb_axil_regbank;

   localparam int DW = 32;
   localparam int NR = 12;
   localparam int AW = 6;
   localparam logic [NR-1:0] RO = 12'h004;
   // A 12-slot map leaves indices 12..15 unmapped inside the 6-bit address space;
   // with 16 slots an address such as 0x40 would not fit the port at all.

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [AW-1:0]       awaddr = '0, araddr = '0;
   logic                awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [DW-1:0]       wdata = '0;
   logic [3:0]          wstrb = '0;
   logic                awready, wready, bvalid, arready, rvalid;
   logic [1:0]          bresp, rresp;
   logic [DW-1:0]       rdata;
   logic [NR*DW-1:0]    reg_out;
   logic [NR-1:0]       reg_wr_pulse;
   logic [NR*DW-1:0]    hw_status = '0;

   axil_regbank #(
      .C_S_AXI_DATA_WIDTH (DW),
      .NUM_REGS           (NR),
      .RO_MASK            (RO)
   ) dut (
      .ACLK          (clk),
      .ARESETN       (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (3'b000),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (3'b000),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_out       (reg_out),
      .reg_wr_pulse  (reg_wr_pulse),
      .hw_status     (hw_status)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [DW-1:0] mdl [NR];
   logic [AW-1:0] aw_fifo [$];
   logic [DW-1:0] wd_fifo [$];
   logic [3:0]    ws_fifo [$];
   bit            b_pend = 0, r_pend = 0, live = 0;
   logic [1:0]    b_exp = '0, r_exp_resp = '0;
   logic [DW-1:0] r_exp_data = '0;
   logic [NR-1:0] pulse_exp = '0;

   always @(posedge clk or negedge rst_n) begin
      int idx;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [3:0]    s;
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) mdl[i] = '0;
         aw_fifo.delete(); wd_fifo.delete(); ws_fifo.delete();
         b_pend = 0; r_pend = 0; live = 0; pulse_exp = '0;
      end else begin
         live = 1;
         pulse_exp = '0;
         if (rvalid && rready) r_pend = 0;
         if (bvalid && bready) b_pend = 0;
         // reads resolve against the map before this edge's write lands
         if (arvalid && arready) begin
            idx = int'(araddr) / 4;
            r_pend = 1;
            if (idx >= NR) begin
               r_exp_data = '0; r_exp_resp = 2'b10;
            end else if (RO[idx]) begin
               r_exp_data = hw_status[idx*DW +: DW]; r_exp_resp = 2'b00;
            end else begin
               r_exp_data = mdl[idx]; r_exp_resp = 2'b00;
            end
         end
         if (awvalid && awready) aw_fifo.push_back(awaddr);
         if (wvalid && wready) begin
            wd_fifo.push_back(wdata);
            ws_fifo.push_back(wstrb);
         end
         if (aw_fifo.size() > 0 && wd_fifo.size() > 0) begin
            a = aw_fifo.pop_front();
            d = wd_fifo.pop_front();
            s = ws_fifo.pop_front();
            idx = int'(a) / 4;
            b_pend = 1;
            if (idx < NR && !RO[idx]) begin
               for (int b = 0; b < 4; b++)
                  if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
               pulse_exp[idx] = 1'b1;
               b_exp = 2'b00;
            end else begin
               b_exp = 2'b10;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (rst_n && live) begin
         for (int i = 0; i < NR; i++)
            check($sformatf("reg_out[%0d]", i), reg_out[i*DW +: DW], RO[i] ? '0 : mdl[i]);
         check("reg_wr_pulse", reg_wr_pulse, pulse_exp);
         check("bvalid", bvalid, b_pend);
         if (b_pend) begin
            check("bresp", bresp, b_exp);
            check("awready_in_resp", awready, 0);
            check("wready_in_resp", wready, 0);
         end
         check("rvalid", rvalid, r_pend);
         check("arready", arready, !r_pend);
         if (r_pend) begin
            check("rdata", rdata, r_exp_data);
            check("rresp", rresp, r_exp_resp);
         end
      end
   end

   // ---------------- bus tasks ----------------
   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int w_lead, input int b_stall,
                            output logic [1:0] resp, output logic [NR-1:0] pulse);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int cyc = 0;
      logic [1:0] first_resp;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (!w_done) wvalid = 1'b1;
         if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(negedge clk);
         cyc++;
         if (aw_fire) begin aw_done = 1; awvalid = 1'b0; end
         if (w_fire)  begin w_done  = 1; wvalid  = 1'b0; end
         if (w_done && !aw_done) check("wready_after_w", wready, 0);
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_handshakes", {aw_done, w_done}, 2'b11);
      check("b_latency", bvalid, 1);
      resp = bresp;
      pulse = reg_wr_pulse;
      first_resp = bresp;
      for (int k = 0; k < b_stall; k++) begin
         @(negedge clk);
         check("b_stall_valid", bvalid, 1);
         check("b_stall_resp", bresp, first_resp);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input int r_stall,
                           output logic [DW-1:0] data, output logic [1:0] resp);
      bit fire = 0;
      int cyc = 0;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      while (!fire && cyc < 40) begin
         fire = arready;
         @(negedge clk);
         cyc++;
      end
      arvalid = 1'b0;
      check("rd_handshake", fire, 1);
      check("r_latency", rvalid, 1);
      data = rdata;
      resp = rresp;
      for (int k = 0; k < r_stall; k++) begin
         @(negedge clk);
         check("r_stall_valid", rvalid, 1);
         check("r_stall_data", rdata, data);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [NR-1:0] pulse;
   } wr_vec_t;

   wr_vec_t basic [4] = '{
      '{6'h00, 32'h0000_0001, 12'h001},
      '{6'h04, 32'h0000_0002, 12'h002},
      '{6'h0C, 32'h0000_0003, 12'h008},
      '{6'h10, 32'h0000_0004, 12'h010}
   };

   initial begin
      logic [1:0]    resp, resp2;
      logic [DW-1:0] rd, rd2;
      logic [NR-1:0] pl;

      for (int i = 0; i < NR; i++) mdl[i] = '0;
      hw_status[2*DW +: DW] = 32'hCAFE_F00D;

      repeat (3) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      check("rst_rdata", rdata, 0);
      check("rst_pulse", reg_wr_pulse, 0);
      check("rst_reg_out", |reg_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_awready", awready, 1);
      check("post_rst_wready", wready, 1);
      check("post_rst_arready", arready, 1);

      // basic writes and read-back
      foreach (basic[i]) begin
         axi_write(basic[i].addr, basic[i].data, 4'hF, 0, 0, resp, pl);
         check("basic_bresp", resp, 2'b00);
         check("basic_pulse", pl, basic[i].pulse);
      end
      foreach (basic[i]) begin
         axi_read(basic[i].addr, 0, rd, resp);
         check("basic_rdata", rd, basic[i].data);
         check("basic_rresp", resp, 2'b00);
      end
      axi_read(6'h05, 0, rd, resp);
      check("byte_offset_ignored", rd, 32'h0000_0002);

      // byte strobes
      axi_write(6'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, pl);
      axi_write(6'h00, 32'h1234_5678, 4'b0101, 0, 0, resp, pl);
      axi_read(6'h00, 0, rd, resp);
      check("strobe_merge", rd, 32'hFF34_FF78);

      // zero strobe still pulses, value unchanged
      axi_write(6'h1C, 32'hFFFF_FFFF, 4'h0, 0, 0, resp, pl);
      check("zero_strb_resp", resp, 2'b00);
      check("zero_strb_pulse", pl, 12'h080);
      check("zero_strb_value", reg_out[7*DW +: DW], 32'h0);

      // W three cycles ahead of AW
      axi_write(6'h18, 32'hA5A5_A5A5, 4'hF, 3, 0, resp, pl);
      check("w_first_resp", resp, 2'b00);
      check("w_first_reg_out", reg_out[6*DW +: DW], 32'hA5A5_A5A5);

      // read-only slot
      axi_write(6'h08, 32'h1111_1111, 4'hF, 0, 0, resp, pl);
      check("ro_write_resp", resp, 2'b10);
      check("ro_write_pulse", pl, 12'h000);
      check("ro_reg_out", reg_out[2*DW +: DW], 32'h0);
      axi_read(6'h08, 0, rd, resp);
      check("ro_read_data", rd, 32'hCAFE_F00D);
      check("ro_read_resp", resp, 2'b00);
      fork
         axi_read(6'h08, 4, rd, resp);
         begin
            repeat (3) @(negedge clk);
            hw_status[2*DW +: DW] = 32'h0BAD_BEEF;
         end
      join
      check("ro_sampled_at_ar", rd, 32'hCAFE_F00D);
      hw_status[2*DW +: DW] = 32'hCAFE_F00D;

      // unmapped slots
      axi_write(6'h30, 32'h5555_5555, 4'hF, 0, 0, resp, pl);
      check("oor_write_resp", resp, 2'b10);
      check("oor_write_pulse", pl, 12'h000);
      axi_read(6'h3C, 0, rd, resp);
      check("oor_read_data", rd, 32'h0);
      check("oor_read_resp", resp, 2'b10);

      // held-off responses
      axi_write(6'h04, 32'hDEAD_BEEF, 4'hF, 0, 5, resp, pl);
      check("stall_bresp", resp, 2'b00);
      axi_read(6'h04, 5, rd, resp);
      check("stall_rdata", rd, 32'hDEAD_BEEF);

      // same-cycle read and write commit to one register
      fork
         axi_write(6'h0C, 32'h0000_0033, 4'hF, 0, 0, resp, pl);
         axi_read(6'h0C, 0, rd2, resp2);
      join
      check("same_cycle_old_value", rd2, 32'h0000_0003);
      axi_read(6'h0C, 0, rd, resp);
      check("same_cycle_new_value", rd, 32'h0000_0033);

      // reset in the middle of outstanding responses
      @(negedge clk);
      awaddr = 6'h04; wdata = 32'h0000_00AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 6'h00; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("mid_bvalid_before", bvalid, 1);
      check("mid_rvalid_before", rvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_bvalid", bvalid, 0);
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_awready", awready, 0);
      check("mid_rst_arready", arready, 0);
      check("mid_rst_reg_out", |reg_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      axi_read(6'h00, 0, rd, resp);
      check("after_rst_reg0", rd, 32'h0);
      axi_read(6'h04, 0, rd, resp);
      check("after_rst_reg1", rd, 32'h0);
      axi_read(6'h08, 0, rd, resp);
      check("after_rst_ro", rd, 32'hCAFE_F00D);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
